// File: rtl/bmem_line_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// bmem_arb_pkg
// Shared types and constants for the bmem line arbiter.
//   ADDR_W      byte address width
//   BEAT_W      bmem data beat width
//   NUM_BEATS   beats per cache line
//   LINE_W      cache line width (NUM_BEATS*BEAT_W)
//   BEAT_IDX_W  width of the beat counter
//   arb_state_t arbiter FSM states
//   client_id_t identifies one of the two line clients
//   line_align  clears the byte-in-line offset of an address
// -----------------------------------------------------------------------------
package bmem_arb_pkg;

    localparam int ADDR_W     = 32;
    localparam int BEAT_W     = 64;
    localparam int NUM_BEATS  = 4;
    localparam int LINE_W     = NUM_BEATS * BEAT_W;
    localparam int BEAT_IDX_W = $clog2(NUM_BEATS);
    localparam int LINE_BYTES = LINE_W / 8;

    typedef enum logic [2:0] {
        IDLE,
        RD_CMD,
        RD_WAIT,
        WR_BURST,
        RESP
    } arb_state_t;

    typedef logic client_id_t;

    function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] a);
        return a & ~ADDR_W'(LINE_BYTES - 1);
    endfunction

endpackage

// File: rtl/bmem_line_arbiter_if.sv
// -----------------------------------------------------------------------------
// bmem_line_arbiter_if
// Bundles the two line-client request/response ports and the 64-bit bmem
// port of the memory controller.
//   c_addr/c_read/c_write/c_wdata  per-client line requests (level, held)
//   c_rdata/c_resp                 assembled read line and completion pulse
//   bmem_addr/read/write/wdata     command and write beats to the controller
//   bmem_ready                     controller accepts command/beat
//   bmem_raddr/rdata/rvalid        returning read beats
//   raddr_err                      sticky read-tag mismatch flag
// Modports:
//   master  the arbiter's view
//   slave   the environment's view (clients + controller)
// -----------------------------------------------------------------------------
interface bmem_line_arbiter_if;
    import bmem_arb_pkg::*;

    logic [1:0][ADDR_W-1:0] c_addr;
    logic [1:0]             c_read;
    logic [1:0]             c_write;
    logic [1:0][LINE_W-1:0] c_wdata;
    logic [LINE_W-1:0]      c_rdata;
    logic [1:0]             c_resp;

    logic [ADDR_W-1:0]      bmem_addr;
    logic                   bmem_read;
    logic                   bmem_write;
    logic [BEAT_W-1:0]      bmem_wdata;
    logic                   bmem_ready;
    logic [ADDR_W-1:0]      bmem_raddr;
    logic [BEAT_W-1:0]      bmem_rdata;
    logic                   bmem_rvalid;

    logic                   raddr_err;

    modport master (
        input  c_addr, c_read, c_write, c_wdata,
        output c_rdata, c_resp,
        output bmem_addr, bmem_read, bmem_write, bmem_wdata,
        input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid,
        output raddr_err
    );

    modport slave (
        output c_addr, c_read, c_write, c_wdata,
        input  c_rdata, c_resp,
        input  bmem_addr, bmem_read, bmem_write, bmem_wdata,
        output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid,
        input  raddr_err
    );

endinterface

// File: rtl/bmem_line_arbiter_rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
// Two-requester round-robin grant. The grant is combinational from the
// request vector; the priority pointer moves to the non-granted client
// whenever grant_i strobes with a valid grant.
//   clk, rst     clock, synchronous active-high reset
//   req_i        request vector
//   grant_i      grant taken this cycle (pointer update strobe)
//   gnt_valid_o  at least one requester
//   gnt_id_o     granted client
// -----------------------------------------------------------------------------
module rr_arbiter2
    import bmem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       grant_i,
    output logic       gnt_valid_o,
    output client_id_t gnt_id_o
);

    client_id_t ptr_q;

    always_comb begin
        gnt_valid_o = |req_i;
        // Pointer only matters on contention; a lone requester always wins.
        if (req_i == 2'b11) begin
            gnt_id_o = ptr_q;
        end else begin
            gnt_id_o = req_i[1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else if (grant_i && gnt_valid_o) begin
            ptr_q <= ~gnt_id_o;
        end
    end

endmodule

// File: rtl/bmem_line_arbiter.sv
// -----------------------------------------------------------------------------
// bmem_line_arbiter
// Arbitrates two line-granular cache clients onto one 64-bit bmem port.
// A 256-bit line read becomes one read command plus four returning beats that
// are reassembled; a line write becomes a four-beat write burst. One
// transaction is outstanding at a time.
//   clk   system clock
//   rst   synchronous active-high reset
//   bus   bmem_line_arbiter_if.master (client ports + bmem port + raddr_err)
// Optional build macro:
//   BMEM_ARB_RADDR_CHECK_EN  compare each returning beat's bmem_raddr with
//                            the latched line address; a mismatch sets the
//                            sticky raddr_err. Undefined: raddr_err is 0.
// -----------------------------------------------------------------------------
module bmem_line_arbiter
    import bmem_arb_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    bmem_line_arbiter_if.master bus
);

    arb_state_t            state_q, state_d;
    logic [BEAT_IDX_W-1:0] beat_q, beat_d;

    client_id_t            id_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [LINE_W-1:0]     wdata_q;
    logic [LINE_W-1:0]     line_buf_q, line_buf_d;
    logic [LINE_W-1:0]     rdata_q;

    logic [1:0]            req;
    logic                  gnt_valid;
    client_id_t            gnt_id;
    logic                  grant;
    logic                  last_beat;
    logic                  rd_beat;

    assign req       = bus.c_read | bus.c_write;
    assign last_beat = (beat_q == BEAT_IDX_W'(NUM_BEATS - 1));
    // Returning beats are only meaningful while a read is waiting for data.
    assign rd_beat   = (state_q == RD_WAIT) && bus.bmem_rvalid;

    rr_arbiter2 u_rr (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req),
        .grant_i     (grant),
        .gnt_valid_o (gnt_valid),
        .gnt_id_o    (gnt_id)
    );

    // ---------------------------------------------------------------- FSM
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        grant   = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    grant   = 1'b1;
                    // A client raising both read and write gets the read.
                    state_d = bus.c_read[gnt_id] ? RD_CMD : WR_BURST;
                end
            end
            RD_CMD: begin
                if (bus.bmem_ready) begin
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (bus.bmem_rvalid) begin
                    beat_d = beat_q + 1'b1;
                    if (last_beat) begin
                        state_d = RESP;
                        beat_d  = '0;
                    end
                end
            end
            WR_BURST: begin
                if (bus.bmem_ready) begin
                    beat_d = beat_q + 1'b1;
                    if (last_beat) begin
                        state_d = RESP;
                        beat_d  = '0;
                    end
                end
            end
            RESP: begin
                // No grant here: the client needs this cycle to drop its request.
                state_d = IDLE;
                beat_d  = '0;
            end
            default: begin
                state_d = IDLE;
                beat_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

    // ----------------------------------------------------------- datapath
    always_comb begin
        line_buf_d = line_buf_q;
        line_buf_d[int'(beat_q)*BEAT_W +: BEAT_W] = bus.bmem_rdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            line_buf_q <= '0;
            rdata_q    <= '0;
        end else begin
            // Everything is captured at grant so later client changes are harmless.
            if (grant) begin
                id_q    <= gnt_id;
                addr_q  <= line_align(bus.c_addr[gnt_id]);
                wdata_q <= bus.c_wdata[gnt_id];
            end
            if (rd_beat) begin
                line_buf_q <= line_buf_d;
                // c_rdata only changes when a whole line has been assembled.
                if (last_beat) begin
                    rdata_q <= line_buf_d;
                end
            end
        end
    end

    // ------------------------------------------------------------ outputs
    assign bus.bmem_addr  = addr_q;
    assign bus.bmem_read  = (state_q == RD_CMD);
    assign bus.bmem_write = (state_q == WR_BURST);
    assign bus.bmem_wdata = (state_q == WR_BURST) ? wdata_q[int'(beat_q)*BEAT_W +: BEAT_W]
                                                  : '0;
    assign bus.c_resp     = (state_q == RESP) ? (2'b01 << id_q) : 2'b00;
    assign bus.c_rdata    = rdata_q;

`ifdef BMEM_ARB_RADDR_CHECK_EN
    logic raddr_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            raddr_err_q <= 1'b0;
        end else if (rd_beat && (bus.bmem_raddr != addr_q)) begin
            raddr_err_q <= 1'b1;
        end
    end

    assign bus.raddr_err = raddr_err_q;
`else
    logic unused_raddr;
    assign unused_raddr  = ^bus.bmem_raddr;
    assign bus.raddr_err = 1'b0;
`endif

endmodule

// File: tb/tb_bmem_line_arbiter.sv
module tb_bmem_line_arbiter;
    import bmem_arb_pkg::*;

    typedef struct {
        logic              id;
        logic              is_rd;
        logic [LINE_W-1:0] line;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bmem_line_arbiter_if bus();

    bmem_line_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   total = 0;
    int   bad = 0;
    int   acc_beats = 0;
    exp_t exp_q[$];

`ifdef BMEM_ARB_RADDR_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    task automatic check(input string tag, input logic [LINE_W-1:0] obs,
                         input logic [LINE_W-1:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [LINE_W-1:0] mk_line(input logic [63:0] seed);
        return {seed ^ 64'h3, seed ^ 64'h2, seed ^ 64'h1, seed};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic id, input logic is_rd, input logic [LINE_W-1:0] line);
        exp_t e;
        e.id    = id;
        e.is_rd = is_rd;
        e.line  = line;
        exp_q.push_back(e);
    endtask

    task automatic clear_inputs();
        bus.c_addr      = '0;
        bus.c_read      = 2'b00;
        bus.c_write     = 2'b00;
        bus.c_wdata     = '0;
        bus.bmem_ready  = 1'b0;
        bus.bmem_raddr  = '0;
        bus.bmem_rdata  = '0;
        bus.bmem_rvalid = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_c_resp"},     LINE_W'(bus.c_resp),     '0);
        check({tag, "_c_rdata"},    bus.c_rdata,             '0);
        check({tag, "_bmem_addr"},  LINE_W'(bus.bmem_addr),  '0);
        check({tag, "_bmem_read"},  LINE_W'(bus.bmem_read),  '0);
        check({tag, "_bmem_write"}, LINE_W'(bus.bmem_write), '0);
        check({tag, "_bmem_wdata"}, LINE_W'(bus.bmem_wdata), '0);
        check({tag, "_raddr_err"},  LINE_W'(bus.raddr_err),  '0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        exp_q.delete();
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Plays the controller for one read: accepts the command (after one stall
    // cycle) and returns nbeats beats in order. bad_beat carries bad_raddr.
    task automatic serve_read(input logic [ADDR_W-1:0] exp_addr, input logic [LINE_W-1:0] line,
                              input logic [ADDR_W-1:0] raddr, input int bad_beat,
                              input logic [ADDR_W-1:0] bad_raddr, input int nbeats);
        int n = 0;
        while (bus.bmem_read !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("rd_cmd", LINE_W'(bus.bmem_read), LINE_W'(1'b1));
        check("rd_addr", LINE_W'(bus.bmem_addr), LINE_W'(exp_addr));
        tick();
        check("rd_cmd_hold", LINE_W'(bus.bmem_read), LINE_W'(1'b1));
        bus.bmem_ready = 1'b1;
        tick();
        bus.bmem_ready = 1'b0;
        check("rd_cmd_drop", LINE_W'(bus.bmem_read), '0);
        for (int i = 0; i < nbeats; i++) begin
            bus.bmem_rvalid = 1'b1;
            bus.bmem_rdata  = line[i*BEAT_W +: BEAT_W];
            bus.bmem_raddr  = (i == bad_beat) ? bad_raddr : raddr;
            tick();
        end
        bus.bmem_rvalid = 1'b0;
    endtask

    task automatic wait_resp(input int id);
        int n = 0;
        while (bus.c_resp === 2'b00 && n < 40) begin
            tick();
            n++;
        end
        check("resp_seen", LINE_W'(bus.c_resp), LINE_W'(2'b01 << id));
        bus.c_read[id]  = 1'b0;
        bus.c_write[id] = 1'b0;
        tick();
        check("resp_one_cycle", LINE_W'(bus.c_resp), '0);
    endtask

    // Scoreboard: every completion pulse is matched against the oldest entry.
    always @(negedge clk) begin
        if (bus.bmem_write === 1'b1 && bus.bmem_ready === 1'b1) begin
            acc_beats++;
        end
        if (bus.c_resp !== 2'b00) begin
            if (exp_q.size() == 0) begin
                check("resp_unexpected", LINE_W'(bus.c_resp), '0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_resp_id", LINE_W'(bus.c_resp), LINE_W'(2'b01 << e.id));
                if (e.is_rd) begin
                    check("sb_rdata", bus.c_rdata, e.line);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "simulation timeout");
    end

    initial begin
        logic [LINE_W-1:0] l1, la, lb, lc, ld, l4, l5, l6, wl;
        logic [63:0]       wexp[6];
        logic [5:0]        rdy_pat;
        int                n;

        l1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        la = mk_line(64'hA0A0_0000_0000_0100);
        lb = mk_line(64'hB0B0_0000_0000_0200);
        lc = mk_line(64'hC0C0_0000_0000_0300);
        ld = mk_line(64'hD0D0_0000_0000_0400);
        l4 = mk_line(64'h4040_4040_0000_1240);
        l5 = mk_line(64'h5050_5050_0000_2020);
        l6 = mk_line(64'h6060_6060_0000_1220);

        // Reset state
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        check_outputs_zero("reset");
        rst = 1'b0;

        // Read, client 0 only
        bus.c_addr[0] = 32'h0000_1234;
        bus.c_read[0] = 1'b1;
        push_exp(1'b0, 1'b1, l1);
        serve_read(32'h0000_1220, l1, 32'h0000_1220, -1, '0, 4);
        wait_resp(0);
        check("rdata_hold", bus.c_rdata, l1);
        check("raddr_err_clean", LINE_W'(bus.raddr_err), '0);

        // Simultaneous requests after reset: 0, 1, then 0, 1 again
        do_reset();
        bus.c_addr[0] = 32'h0000_0100;
        bus.c_addr[1] = 32'h0000_0200;
        bus.c_read    = 2'b11;
        push_exp(1'b0, 1'b1, la);
        push_exp(1'b1, 1'b1, lb);
        serve_read(32'h0000_0100, la, 32'h0000_0100, -1, '0, 4);
        wait_resp(0);
        serve_read(32'h0000_0200, lb, 32'h0000_0200, -1, '0, 4);
        wait_resp(1);
        bus.c_addr[0] = 32'h0000_0300;
        bus.c_addr[1] = 32'h0000_0400;
        bus.c_read    = 2'b11;
        push_exp(1'b0, 1'b1, lc);
        push_exp(1'b1, 1'b1, ld);
        serve_read(32'h0000_0300, lc, 32'h0000_0300, -1, '0, 4);
        wait_resp(0);
        serve_read(32'h0000_0400, ld, 32'h0000_0400, -1, '0, 4);
        wait_resp(1);

        // Write with backpressure on the 2nd and 3rd burst cycles
        wl = {64'hDDDD_0000_0000_0004, 64'hCCCC_0000_0000_0003,
              64'hBBBB_0000_0000_0002, 64'hAAAA_0000_0000_0001};
        wexp[0] = 64'hAAAA_0000_0000_0001;
        wexp[1] = 64'hBBBB_0000_0000_0002;
        wexp[2] = 64'hBBBB_0000_0000_0002;
        wexp[3] = 64'hBBBB_0000_0000_0002;
        wexp[4] = 64'hCCCC_0000_0000_0003;
        wexp[5] = 64'hDDDD_0000_0000_0004;
        rdy_pat = 6'b111001;  // bit k = ready in burst cycle k
        bus.c_addr[1]  = 32'h0000_5678;
        bus.c_wdata[1] = wl;
        bus.c_write[1] = 1'b1;
        acc_beats      = 0;
        push_exp(1'b1, 1'b0, '0);
        n = 0;
        while (bus.bmem_write !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("wr_addr", LINE_W'(bus.bmem_addr), LINE_W'(32'h0000_5660));
        for (int k = 0; k < 6; k++) begin
            bus.bmem_ready = rdy_pat[k];
            check("wr_valid", LINE_W'(bus.bmem_write), LINE_W'(1'b1));
            check("wr_beat", LINE_W'(bus.bmem_wdata), LINE_W'(wexp[k]));
            tick();
        end
        bus.bmem_ready = 1'b0;
        check("wr_accepted", LINE_W'(acc_beats), LINE_W'(4));
        check("wr_done", LINE_W'(bus.bmem_write), '0);
        wait_resp(1);

        // Stray rvalid while IDLE, then a normal read
        bus.bmem_rvalid = 1'b1;
        bus.bmem_rdata  = 64'hDEAD_BEEF_DEAD_BEEF;
        bus.bmem_raddr  = 32'h0000_1240;
        tick();
        bus.bmem_rvalid = 1'b0;
        check("stray_no_cmd", LINE_W'(bus.bmem_read), '0);
        bus.c_addr[0] = 32'h0000_1240;
        bus.c_read[0] = 1'b1;
        push_exp(1'b0, 1'b1, l4);
        serve_read(32'h0000_1240, l4, 32'h0000_1240, -1, '0, 4);
        wait_resp(0);

        // Reset after two read beats, then a fresh read
        bus.c_addr[0] = 32'h0000_2000;
        bus.c_read[0] = 1'b1;
        serve_read(32'h0000_2000, l5, 32'h0000_2000, -1, '0, 2);
        rst = 1'b1;
        clear_inputs();
        tick();
        check_outputs_zero("midrst");
        rst = 1'b0;
        tick();
        check("midrst_no_resp", LINE_W'(bus.c_resp), '0);
        bus.c_addr[0] = 32'h0000_2020;
        bus.c_read[0] = 1'b1;
        push_exp(1'b0, 1'b1, l5);
        serve_read(32'h0000_2020, l5, 32'h0000_2020, -1, '0, 4);
        wait_resp(0);

        // Beat 2 returns with a wrong address tag
        bus.c_addr[0] = 32'h0000_1220;
        bus.c_read[0] = 1'b1;
        push_exp(1'b0, 1'b1, l6);
        serve_read(32'h0000_1220, l6, 32'h0000_1220, 2, 32'h0000_2000, 4);
        wait_resp(0);
        check("raddr_err", LINE_W'(bus.raddr_err), LINE_W'(EXP_ERR));
        tick();
        tick();
        check("raddr_err_sticky", LINE_W'(bus.raddr_err), LINE_W'(EXP_ERR));
        check("sb_drained", LINE_W'(exp_q.size()), '0);

        do_reset();
        check_outputs_zero("final_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
